uart_baud_gen: RTL and testbench
================================

# uart_baud_gen

Runtime-programmable fractional baud generator for the UART datapath. Divides `clk` by a programmable integer plus fractional divisor and produces an oversampling tick (`os_tick`, for the RX sampler). It also produces a bit-rate tick (`baud_tick`, for the TX shifter) every `OS_RATE` oversample ticks. RX can re-align the bit phase to a detected start edge via `resync`.

## Interface
- `CNT_W`, 16: width of integer divisor and period counter.
- `FRAC_W`, 4: width of fractional divisor and phase accumulator.
- `OS_RATE`, 16: oversample ticks per bit; power of two, ≥ 2.
- `DEFAULT_INT`, 78: integer divisor loaded at reset (12 MHz / (9600 × 16) = 78.125).
- `DEFAULT_FRAC`, 2: fractional divisor loaded at reset (0.125 × 2^FRAC_W).

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable; low freezes all counters.
- `resync`  in  1  one-cycle pulse; restarts bit phase.
- `cfg_load`  in  1  one-cycle pulse; captures `div_int`/`div_frac` as pending divisor.
- `div_int`  in  CNT_W  integer divisor, in clk cycles per oversample period.
- `div_frac`  in  FRAC_W  fractional divisor, in units of 2^-FRAC_W cycles.
- `os_tick`  out  1  registered one-cycle oversample strobe.
- `baud_tick`  out  1  registered one-cycle bit strobe; always coincident with an `os_tick`.
- `cfg_pend`  out  1  high while a loaded divisor is waiting to be applied.

## Operation
- **Registers:**
  - `per_cnt` (CNT_W): period counter.
  - `acc` (FRAC_W): phase accumulator.
  - `os_cnt` (log2 OS_RATE): oversample counter.
  - `extra` (1 bit): stretch flag.
  - Active divisor `act_int`/`act_frac`.
  - Pending divisor `pnd_int`/`pnd_frac`, plus `cfg_pend`.
- **Reset:**
  - All counters are 0; `extra` = 0.
  - `act_*` = `DEFAULT_*`; `pnd_*` = `DEFAULT_*`.
  - `os_tick` = `baud_tick` = `cfg_pend` = 0.
- **Effective divisor:** `eff_int = (act_int == 0) ? 1 : act_int`. A value of 0 is never a divide-by-zero.
- **Period end (en=1):**
  - A period ends when `per_cnt == eff_int-1+extra`.
  - In that cycle: `os_tick` ← 1 and `per_cnt` ← 0.
  - `{carry, acc} ← acc + act_frac`; `extra` ← `carry`, so the next period is one cycle longer.
  - `os_cnt` increments and wraps at `OS_RATE-1`.
  - `baud_tick` ← 1 when `os_cnt == OS_RATE-1`.
  - Otherwise `per_cnt` increments, and both ticks ← 0.
- **Config:**
  - `cfg_load` copies the inputs to `pnd_*` and sets `cfg_pend`.
  - Pending is applied to `act_*` at the next period end, or immediately when `en` = 0. `cfg_pend` then clears.
  - A `cfg_load` while pending overwrites `pnd_*`.
  - `acc` is not cleared on apply.
- **resync** (priority over everything except reset):
  - `per_cnt`, `acc`, `extra`, `os_cnt` ← 0.
  - Both ticks ← 0 that cycle.
  - A pending config is applied in the same cycle.
- **en=0:** all counters hold, and both ticks ← 0. Rising `en` resumes from the held state.
- **Simultaneous `cfg_load` + period end:** the old pending value, if any, is applied. The new value becomes pending.

## Timing
- Ticks are registered: visible the cycle after the terminal count.
- First `os_tick` occurs `eff_int` cycles after the first `en`=1 edge following reset or resync.
- Average oversample period = `act_int + act_frac/2^FRAC_W` cycles. Period jitter ≤ 1 cycle.
- Bit period = `OS_RATE` oversample periods.
- A divisor change takes effect from the first period after the next `os_tick`. There is no partial period.
- `rst_n` assertion mid-period forces all outputs to 0 asynchronously.

## Configuration
- **`UART_BAUD_FRAC_EN` defined:** phase accumulator present, behaviour as above.
- **Undefined:**
  - `acc`/`extra` are not built, and `div_frac`/`pnd_frac`/`act_frac` are ignored.
  - The period is exactly `eff_int` cycles.
  - The `div_frac` port remains, unused.

## Structure
- Shared package `uart_pkg`:
  - `BAUD_CNT_W`, `BAUD_FRAC_W`, `UART_OS_RATE` constants.
  - Default divisor constants for 12 MHz / 9600.
  - Typedef `baud_cfg_t` = {int, frac}.
- Sub-module `baud_frac_div`: `per_cnt`/`acc`/`extra`. Outputs the period-end strobe. Top level adds `os_cnt`, config staging and `resync`.

## Test plan
- **Reset defaults, en=1 held, FRAC_EN:**
  - First `os_tick` 78 cycles after `en`.
  - Oversample periods follow 78×7 then 79, repeating.
  - `baud_tick` every exactly 1250 cycles.
- **Same config, FRAC_EN undefined:** `os_tick` every 78 cycles; `baud_tick` every 1248 cycles.
- **`cfg_load` with int=5, frac=0 mid-period:**
  - `cfg_pend`=1 until the next `os_tick`.
  - Then `os_tick` every 5 cycles and `baud_tick` every 80 cycles.
- **`resync` pulse 40 cycles into a bit:**
  - No ticks that cycle.
  - Next `os_tick` 78 cycles later.
  - Next `baud_tick` 1250 cycles after `resync`.
- **div_int=0 and div_int=1:** `os_tick` every cycle with frac=0. With frac=8, periods alternate 1 and 2 cycles.
- **en low for 100 cycles mid-period, then high:**
  - No ticks while low.
  - Remaining period resumes exactly.
  - `rst_n` pulse mid-bit zeroes outputs and restores defaults.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud constants and divisor config type
package uart_pkg;

  localparam int BAUD_CNT_W   = 16;
  localparam int BAUD_FRAC_W  = 4;
  localparam int UART_OS_RATE = 16;

  // 12 MHz / (9600 * 16) = 78.125 -> 78 + 2/16
  localparam int BAUD_DEFAULT_INT  = 78;
  localparam int BAUD_DEFAULT_FRAC = 2;

  typedef struct packed {
    logic [BAUD_CNT_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_cfg_t;

endpackage

// File: rtl/baud_frac_div.sv
// rtl/baud_frac_div.sv - period counter with fractional stretch
// Fractional accumulator is built only when UART_BAUD_FRAC_EN is defined.
module baud_frac_div
  import uart_pkg::*;
#(
  parameter int CNT_W  = BAUD_CNT_W,
  parameter int FRAC_W = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              period_end
);

  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] eff_int;
  logic [CNT_W:0]   last_cnt;

  assign eff_int = (div_int == '0) ? CNT_W'(1) : div_int;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum  = {1'b0, acc} + {1'b0, div_frac};
  assign last_cnt = {1'b0, eff_int - CNT_W'(1)} + {{CNT_W{1'b0}}, extra};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      extra <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      extra <= 1'b0;
    end else if (period_end) begin
      acc   <= acc_sum[FRAC_W-1:0];
      extra <= acc_sum[FRAC_W];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign last_cnt    = {1'b0, eff_int - CNT_W'(1)};
`endif

  // >= so a divisor shrunk while frozen ends the held period instead of overrunning
  assign period_end = en && ({1'b0, per_cnt} >= last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (clr || period_end) begin
      per_cnt <= '0;
    end else if (en) begin
      per_cnt <= per_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional UART baud generator with oversample and bit ticks
// Fractional divisor active only when UART_BAUD_FRAC_EN is defined.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W        = BAUD_CNT_W,
  parameter int FRAC_W       = BAUD_FRAC_W,
  parameter int OS_RATE      = UART_OS_RATE,
  parameter int DEFAULT_INT  = BAUD_DEFAULT_INT,
  parameter int DEFAULT_FRAC = BAUD_DEFAULT_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              resync,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              cfg_pend
);

  localparam int              OS_W    = $clog2(OS_RATE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam baud_cfg_t DEFAULT_CFG = '{
    div_int:  BAUD_CNT_W'(DEFAULT_INT),
    div_frac: BAUD_FRAC_W'(DEFAULT_FRAC)
  };

  baud_cfg_t       act;
  baud_cfg_t       pnd;
  logic [OS_W-1:0] os_cnt;
  logic            period_end;
  logic            tick;
  logic            apply;

  baud_frac_div #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (resync),
    .div_int    (CNT_W'(act.div_int)),
    .div_frac   (FRAC_W'(act.div_frac)),
    .period_end (period_end)
  );

  assign tick = period_end && !resync;
  // Divisor swaps only on a period boundary, on resync, or while frozen
  assign apply = cfg_pend && (resync || period_end || !en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      cfg_pend  <= 1'b0;
      act       <= DEFAULT_CFG;
      pnd       <= DEFAULT_CFG;
    end else begin
      os_tick   <= tick;
      baud_tick <= tick && (os_cnt == OS_LAST);
      if (resync) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + OS_W'(1);
      end
      if (apply) begin
        act <= pnd;
      end
      if (cfg_load) begin
        pnd.div_int  <= BAUD_CNT_W'(div_int);
        pnd.div_frac <= BAUD_FRAC_W'(div_frac);
        cfg_pend     <= 1'b1;
      end else if (apply) begin
        cfg_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - scoreboard bench for uart_baud_gen
// Follows UART_BAUD_FRAC_EN the same way as the design.
module tb_uart_baud_gen;

  localparam int OS   = 16;
  localparam int FSPN = 16;
`ifdef UART_BAUD_FRAC_EN
  localparam int BAUD_DEF = 1250;
`else
  localparam int BAUD_DEF = 1248;
`endif

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic        resync   = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] div_int  = '0;
  logic [3:0]  div_frac = '0;
  logic        os_tick;
  logic        baud_tick;
  logic        cfg_pend;

  uart_baud_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .resync    (resync),
    .cfg_load  (cfg_load),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .cfg_pend  (cfg_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic os;
    logic baud;
    logic pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;

  function automatic void check_bit(string name, logic got, logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0b want %0b", name, ncyc, got, want);
    end
  endfunction

  function automatic void check_int(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, ncyc, got, want);
    end
  endfunction

  // Reference model: elapsed cycles in the current period, fractional phase
  // in 1/16 cycle units, bit position, and active/pending divisors.
  int m_el, m_phase, m_extra, m_os, m_int, m_frac, m_pint, m_pfrac;
  bit m_pend;

  always @(posedge clk) begin
    exp_t e;
    bit   apply;
    int   len;
    e     = '0;
    apply = 1'b0;
    if (!rst_n) begin
      m_el = 0; m_phase = 0; m_extra = 0; m_os = 0;
      m_int = 78; m_frac = 2; m_pint = 78; m_pfrac = 2; m_pend = 1'b0;
    end else begin
      if (resync) begin
        m_el = 0; m_phase = 0; m_extra = 0; m_os = 0;
        apply = m_pend;
      end else if (!en) begin
        apply = m_pend;
      end else begin
        len = ((m_int == 0) ? 1 : m_int) + m_extra;
        if (m_el + 1 >= len) begin
          e.os   = 1'b1;
          e.baud = (m_os == OS - 1);
          m_os   = (m_os + 1) % OS;
          m_el   = 0;
`ifdef UART_BAUD_FRAC_EN
          m_extra = (m_phase + m_frac >= FSPN) ? 1 : 0;
          m_phase = (m_phase + m_frac) % FSPN;
`endif
          apply = m_pend;
        end else begin
          m_el++;
        end
      end
      if (apply) begin
        m_int  = m_pint;
        m_frac = m_pfrac;
        m_pend = 1'b0;
      end
      if (cfg_load) begin
        m_pint  = int'(div_int);
        m_pfrac = int'(div_frac);
        m_pend  = 1'b1;
      end
    end
    e.pend = m_pend;
    exp_q.push_back(e);
  end

  int last_os = 0, os_iv = 0, os_prev_iv = 0, os_count = 0;
  int last_baud = 0, baud_iv = 0;

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      check_bit("sb_os_tick", os_tick, e.os);
      check_bit("sb_baud_tick", baud_tick, e.baud);
      check_bit("sb_cfg_pend", cfg_pend, e.pend);
    end
    if (os_tick === 1'b1) begin
      os_prev_iv = os_iv;
      os_iv      = ncyc - last_os;
      last_os    = ncyc;
      os_count++;
    end
    if (baud_tick === 1'b1) begin
      baud_iv   = ncyc - last_baud;
      last_baud = ncyc;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      resync   = 1'b0;
    end
  endtask

  task automatic load(input int i, input int f);
    cfg_load = 1'b1;
    div_int  = 16'(i);
    div_frac = 4'(f);
    cyc(1);
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    cyc(1);
  endtask

  initial begin
    int n0;
    int r;
    cyc(3);
    check_bit("reset_os_tick", os_tick, 1'b0);
    check_bit("reset_baud_tick", baud_tick, 1'b0);
    check_bit("reset_cfg_pend", cfg_pend, 1'b0);

    rst_n = 1'b1;
    en    = 1'b1;
    cyc(2600);
    check_int("baud_period_default", baud_iv, BAUD_DEF);

    cyc(37);
    load(5, 0);
    cyc(400);
    check_int("os_period_int5", os_iv, 5);
    check_int("baud_period_int5", baud_iv, 80);

    load(0, 0);
    cyc(30);
    check_int("os_period_int0", os_iv, 1);
    load(1, 8);
    cyc(30);
`ifdef UART_BAUD_FRAC_EN
    check_int("os_pair_int1_frac8", os_iv + os_prev_iv, 3);
`else
    check_int("os_period_int1", os_iv, 1);
`endif

    load(78, 2);
    cyc(150);
    en = 1'b0;
    cyc(1);
    n0 = os_count;
    cyc(100);
    check_int("ticks_while_en_low", os_count - n0, 0);
    en = 1'b1;
    cyc(300);

    cyc(40);
    pulse_resync();
    cyc(1300);

    en = 1'b0;
    pulse_resync();
    load(5, 0);
    cyc(3);
    en = 1'b1;
    cyc(60);
    check_int("os_period_idle_load", os_iv, 5);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (!en) begin
        if (r < 20) en = 1'b1;
        cyc(1);
      end else if (r < 3 && !m_pend) begin
        en = 1'b0;
        cyc(1);
      end else if (r < 6) begin
        load(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
      end else if (r < 8) begin
        pulse_resync();
      end else begin
        cyc(1);
      end
    end

    en = 1'b1;
    load(200, 3);
    cyc(20);
    load(100, 1);
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_os_tick", os_tick, 1'b0);
    check_bit("async_rst_baud_tick", baud_tick, 1'b0);
    check_bit("async_rst_cfg_pend", cfg_pend, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(200);
    check_int("os_period_after_reset", os_iv, 78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
